result_streamer: RTL
====================

Name: result_streamer

Overview:
- Downstream stage of the masked 2D filter top.
- Once the kernel has filled the output memory, this block reads the filtered image out, byte by byte, and hands each byte to uart_tx.
- Honours host flow control (RTS) and can append an 8-bit modular checksum.
- Replaces the ad-hoc start_send/counter coupling with a self-contained sequencer.

Parameters:
- ADDR_BITS, 9, output memory address width (memory depth = 2**ADDR_BITS).
- DATA_BITS, 8, pixel and UART byte width.
- APPEND_SUM, 1, when 1, the checksum byte is transmitted after the last pixel.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low.
- start  input  1  one-cycle request to stream the output image; sampled only in IDLE.
- len  input  16  number of pixels (w*h); latched on an accepted start.
- mem_addr  output  ADDR_BITS  output memory read address.
- mem_data  input  DATA_BITS  output memory read data; valid one clk after mem_addr.
- host_rts  input  1  host ready; 1 = may start a new byte.
- tx_active  input  1  uart_tx busy flag.
- tx_done  input  1  uart_tx one-cycle byte-complete pulse.
- tx_dv  output  1  one-cycle send strobe to uart_tx.
- tx_byte  output  DATA_BITS  byte to send; stable from the tx_dv cycle until tx_done.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the final byte's tx_done.
- sent_count  output  16  pixels transmitted so far; the checksum byte is not counted.
- checksum  output  DATA_BITS  running sum mod 256 of transmitted pixels.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - mem_addr, tx_dv, tx_byte, busy, done, sent_count and checksum all go to 0.
  - Reset overrides any in-flight transfer. A byte already started in uart_tx finishes on its own; its tx_done is ignored because the block is in IDLE.
- States: IDLE, FETCH, LATCH, ARM, SEND, WAIT_DONE, SUM, FINISH.
- IDLE:
  - On start=1, latch len_q = min(len, 2**ADDR_BITS).
  - Clear sent_count and checksum, set busy=1, go to FETCH.
  - If len_q=0, go to SUM instead when APPEND_SUM=1, otherwise go to FINISH.
- FETCH: drive mem_addr = sent_count[ADDR_BITS-1:0]; next state is LATCH.
- LATCH: register mem_data into tx_byte; go to ARM.
- ARM:
  - Stay in ARM while host_rts=0 or tx_active=1.
  - Otherwise pulse tx_dv=1 for exactly one cycle and go to WAIT_DONE.
- WAIT_DONE: on tx_done:
  - If sending a pixel: checksum += tx_byte (mod 256) and sent_count += 1.
  - Then, if sent_count (after increment) == len_q: go to SUM when APPEND_SUM=1, otherwise to FINISH.
  - Otherwise go back to FETCH.
  - If sending the checksum byte: go to FINISH.
- SUM: tx_byte = checksum; go to ARM, where the checksum byte is sent under the same RTS rules.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. sent_count and checksum hold their values until the next accepted start.
- Latency per pixel: 3 cycles from FETCH to tx_dv when the host and UART are ready, plus the UART frame time.
- Boundary conditions:
  - start while busy=1 is ignored.
  - host_rts dropping after tx_dv does not abort the current byte; it only blocks the next one.
  - tx_done outside WAIT_DONE is ignored.
  - tx_dv is never asserted while tx_active=1.
  - mem_addr never exceeds 2**ADDR_BITS-1 because of the clamp.
  - len > 512 streams exactly 512 pixels.

Test Plan:
- Memory holds 0x01,0x02,0x03 at addresses 0..2; len=3, APPEND_SUM=1, host_rts=1 -> bytes 01,02,03,06 sent in order; done pulses once; sent_count=3, checksum=0x06.
- Memory holds 0xFF,0x02; len=2 -> checksum byte 0x01 (wrap-around); tx_dv pulses exactly 3 times.
- len=4; host_rts forced to 0 after the 2nd tx_dv for 5000 cycles -> the 2nd byte completes normally, no tx_dv while rts=0, and the 3rd byte follows rts rising within 1 cycle.
- len=0 with APPEND_SUM=1 -> single byte 0x00 sent, then done. len=0 with APPEND_SUM=0 -> no tx_dv, and done pulses 2 cycles after start.
- A second start pulse mid-stream, and len=600 -> the second start has no effect; exactly 512 pixel bytes sent; mem_addr max = 0x1FF.
- rst=0 during WAIT_DONE of pixel 2 -> the next cycle shows busy=0, tx_dv=0, sent_count=0; a later start with len=1 streams correctly.

Source files
------------

// File: rtl/result_streamer.sv
// Streams the filtered image from the output memory to uart_tx one byte at a time,
// honouring host RTS and optionally appending an 8-bit modular checksum.
module result_streamer #(
   parameter int unsigned ADDR_BITS  = 9,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned APPEND_SUM = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          len,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic [DATA_BITS-1:0] mem_data,
   input  logic                 host_rts,
   input  logic                 tx_active,
   input  logic                 tx_done,
   output logic                 tx_dv,
   output logic [DATA_BITS-1:0] tx_byte,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          sent_count,
   output logic [DATA_BITS-1:0] checksum
);

   localparam int unsigned LEN_W   = 16;
   localparam int unsigned QW      = LEN_W + 1;
   localparam logic [QW-1:0] MAX_LEN = QW'(2**ADDR_BITS);
   localparam bit HAS_SUM = (APPEND_SUM != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_ARM,
      S_SEND,
      S_WAIT_DONE,
      S_SUM,
      S_FINISH
   } state_t;

   state_t               r_state;
   logic [QW-1:0]        r_len_q;
   logic                 r_sum_phase;

   logic [QW-1:0]        w_len_clamped;
   logic [LEN_W-1:0]     w_count_inc;
   logic                 w_last;
   logic [DATA_BITS-1:0] w_sum_inc;

   // Clamp keeps every generated address inside the memory.
   assign w_len_clamped = ({1'b0, len} > MAX_LEN) ? MAX_LEN : {1'b0, len};
   assign w_count_inc   = sent_count + LEN_W'(1);
   assign w_last        = ({1'b0, w_count_inc} == r_len_q);
   assign w_sum_inc     = checksum + tx_byte;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_len_q     <= '0;
         r_sum_phase <= 1'b0;
         mem_addr    <= '0;
         tx_dv       <= 1'b0;
         tx_byte     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         sent_count  <= '0;
         checksum    <= '0;
      end else begin
         tx_dv <= 1'b0;
         done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len_q     <= w_len_clamped;
                  r_sum_phase <= 1'b0;
                  sent_count  <= '0;
                  checksum    <= '0;
                  busy        <= 1'b1;
                  if (len == '0)
                     r_state <= HAS_SUM ? S_SUM : S_FINISH;
                  else
                     r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               mem_addr <= sent_count[ADDR_BITS-1:0];
               r_state  <= S_LATCH;
            end
            S_LATCH: begin
               tx_byte <= mem_data;
               r_state <= S_ARM;
            end
            S_ARM: begin
               // A new byte only starts when the host is ready and the UART is idle.
               if (host_rts && !tx_active) begin
                  tx_dv   <= 1'b1;
                  r_state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (tx_done) begin
                  if (r_sum_phase) begin
                     r_state <= S_FINISH;
                  end else begin
                     checksum   <= w_sum_inc;
                     sent_count <= w_count_inc;
                     if (w_last)
                        r_state <= HAS_SUM ? S_SUM : S_FINISH;
                     else
                        r_state <= S_FETCH;
                  end
               end
            end
            S_SUM: begin
               tx_byte     <= checksum;
               r_sum_phase <= 1'b1;
               r_state     <= S_ARM;
            end
            S_FINISH: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
